// File: rtl/fp_to_int_if.sv
// Operand/result bundle between a floating-point producer and fp_to_int_converter.
// The master side drives requests; the slave side is the converter.
interface fp_to_int_if #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int INT_WIDTH      = 32
);
  logic                                start_in;
  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   fp_in;
  logic                                busy_out;
  logic                                done_out;
  logic signed [INT_WIDTH-1:0]         int_out;
  logic                                overflow_out;
  logic                                underflow_out;

  modport master (
    output start_in, fp_in,
    input  busy_out, done_out, int_out, overflow_out, underflow_out
  );

  modport slave (
    input  start_in, fp_in,
    output busy_out, done_out, int_out, overflow_out, underflow_out
  );
endinterface

// File: rtl/fp_to_int_converter.sv
// Float (sign, biased exponent, hidden-one mantissa) to signed integer, one shift per cycle.
// Optional macro FP_TO_INT_ROUND_EN selects round-to-nearest-even instead of truncation.
module fp_to_int_converter #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int INT_WIDTH      = 32
) (
  input logic        clk_in,
  input logic        rst_in,
  fp_to_int_if.slave bus
);

  localparam int FP_W  = EXP_WIDTH + MANTISSA_WIDTH + 1;
  localparam int MAG_W = (INT_WIDTH > MANTISSA_WIDTH + 1) ? INT_WIDTH : MANTISSA_WIDTH + 1;
  localparam int CNT_W = $clog2(MAG_W + MANTISSA_WIDTH + 2);
  localparam int BIAS  = (1 << (EXP_WIDTH - 1)) - 1;
`ifdef FP_TO_INT_ROUND_EN
  // e = -1 still reaches the shifter so that 0.5 <= |x| < 1 can round up
  localparam int FLUSH_LIM = -1;
  localparam logic [MAG_W-1:0] MAG_LIMIT = {{(MAG_W-1){1'b0}}, 1'b1} << (INT_WIDTH - 1);
`else
  localparam int FLUSH_LIM = 0;
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLASSIFY = 2'd1,
    SHIFT    = 2'd2,
    FINISH   = 2'd3
  } state_t;

  state_t                   state_r, state_next_s;
  logic [FP_W-1:0]          fp_r;
  logic [MAG_W-1:0]         mag_r;
  logic [CNT_W-1:0]         cnt_r;
  logic                     left_r;
  logic                     sat_r;
  logic                     unf_r;
  logic                     busy_r;
  logic                     done_r;
  logic [INT_WIDTH-1:0]     int_r;
  logic                     ovf_out_r;
  logic                     unf_out_r;
`ifdef FP_TO_INT_ROUND_EN
  logic                     guard_r;
  logic                     sticky_r;
  logic                     norm_r;
  logic                     round_up_s;
`endif

  logic                      sign_s;
  logic [EXP_WIDTH-1:0]      exp_s;
  logic [MANTISSA_WIDTH-1:0] mant_s;
  logic signed [31:0]        e_s;
  logic signed [31:0]        diff_s;
  logic [CNT_W-1:0]          cnt_load_s;
  logic                      cls_zero_s;
  logic                      cls_sat_s;
  logic                      cls_flush_s;
  logic                      cls_norm_s;
  logic [MAG_W-1:0]          mag_fin_s;
  logic [INT_WIDTH-1:0]      mag_int_s;
  logic                      sat_fin_s;
  logic                      unf_fin_s;
  logic [INT_WIDTH-1:0]      result_s;

  assign sign_s     = fp_r[FP_W-1];
  assign exp_s      = fp_r[FP_W-2 -: EXP_WIDTH];
  assign mant_s     = fp_r[MANTISSA_WIDTH-1:0];
  assign e_s        = int'({{(32-EXP_WIDTH){1'b0}}, exp_s}) - BIAS;
  assign diff_s     = e_s - MANTISSA_WIDTH;
  assign cnt_load_s = CNT_W'(diff_s[31] ? -diff_s : diff_s);

  // Operand classification from the latched exponent
  always_comb begin
    cls_zero_s  = 1'b0;
    cls_sat_s   = 1'b0;
    cls_flush_s = 1'b0;
    cls_norm_s  = 1'b0;
    if (exp_s == {EXP_WIDTH{1'b0}}) begin
      cls_zero_s = 1'b1;
    end else if ((exp_s == {EXP_WIDTH{1'b1}}) || (e_s >= $signed(INT_WIDTH - 1))) begin
      cls_sat_s = 1'b1;
    end else if (e_s < $signed(FLUSH_LIM)) begin
      cls_flush_s = 1'b1;
    end else begin
      cls_norm_s = 1'b1;
    end
  end

  // Final magnitude, flags and signed result presented to the FINISH state
  always_comb begin
`ifdef FP_TO_INT_ROUND_EN
    round_up_s = guard_r & (sticky_r | mag_r[0]);
    mag_fin_s  = mag_r + MAG_W'(round_up_s);
    sat_fin_s  = sat_r | (mag_fin_s >= MAG_LIMIT);
    unf_fin_s  = unf_r | (norm_r & (mag_fin_s == {MAG_W{1'b0}}));
`else
    mag_fin_s  = mag_r;
    sat_fin_s  = sat_r;
    unf_fin_s  = unf_r;
`endif
    mag_int_s = mag_fin_s[INT_WIDTH-1:0];
    if (sat_fin_s) begin
      if (sign_s) begin
        result_s = {1'b1, {(INT_WIDTH-1){1'b0}}};
      end else begin
        result_s = {1'b0, {(INT_WIDTH-1){1'b1}}};
      end
    end else if (sign_s) begin
      result_s = -mag_int_s;
    end else begin
      result_s = mag_int_s;
    end
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start_in) begin
          state_next_s = CLASSIFY;
        end else begin
          state_next_s = IDLE;
        end
      end
      CLASSIFY: begin
        if (cls_norm_s && (cnt_load_s != {CNT_W{1'b0}})) begin
          state_next_s = SHIFT;
        end else begin
          state_next_s = FINISH;
        end
      end
      SHIFT: begin
        if (cnt_r == CNT_W'(1)) begin
          state_next_s = FINISH;
        end else begin
          state_next_s = SHIFT;
        end
      end
      FINISH:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Operand capture, denormalising shifter and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fp_r      <= {FP_W{1'b0}};
      mag_r     <= {MAG_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      left_r    <= 1'b0;
      sat_r     <= 1'b0;
      unf_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      int_r     <= {INT_WIDTH{1'b0}};
      ovf_out_r <= 1'b0;
      unf_out_r <= 1'b0;
`ifdef FP_TO_INT_ROUND_EN
      guard_r   <= 1'b0;
      sticky_r  <= 1'b0;
      norm_r    <= 1'b0;
`endif
    end else begin
      busy_r <= (state_next_s != IDLE);
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start_in) begin
            fp_r <= bus.fp_in;
          end
        end
        CLASSIFY: begin
          sat_r  <= cls_sat_s;
          unf_r  <= cls_flush_s | (cls_zero_s & (mant_s != {MANTISSA_WIDTH{1'b0}}));
          left_r <= ~diff_s[31];
          cnt_r  <= cls_norm_s ? cnt_load_s : {CNT_W{1'b0}};
          mag_r  <= cls_norm_s ? MAG_W'({1'b1, mant_s}) : {MAG_W{1'b0}};
`ifdef FP_TO_INT_ROUND_EN
          guard_r  <= 1'b0;
          sticky_r <= 1'b0;
          norm_r   <= cls_norm_s;
`endif
        end
        SHIFT: begin
          cnt_r <= cnt_r - CNT_W'(1);
          if (left_r) begin
            mag_r <= mag_r << 1'b1;
          end else begin
            mag_r <= mag_r >> 1'b1;
`ifdef FP_TO_INT_ROUND_EN
            guard_r  <= mag_r[0];
            sticky_r <= sticky_r | guard_r;
`endif
          end
        end
        FINISH: begin
          done_r    <= 1'b1;
          int_r     <= result_s;
          ovf_out_r <= sat_fin_s;
          unf_out_r <= unf_fin_s;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_out      = busy_r;
  assign bus.done_out      = done_r;
  assign bus.int_out       = int_r;
  assign bus.overflow_out  = ovf_out_r;
  assign bus.underflow_out = unf_out_r;

endmodule

// File: tb/tb_fp_to_int_converter.sv
// Directed bench for fp_to_int_converter with hand-computed results and latencies.
module tb_fp_to_int_converter;

`ifdef FP_TO_INT_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fp_to_int_if #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23), .INT_WIDTH(32)) bus ();

  fp_to_int_converter #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23), .INT_WIDTH(32)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Drive one operand, then wait (bounded) for done and check result, flags, latency, busy.
  task automatic run_op(input string tag, input logic [31:0] fp, input logic [31:0] exp_int,
                        input logic exp_ovf, input logic exp_unf, input int exp_lat);
    int   lat;
    logic busy_ok;
    bus.start_in = 1'b1;
    bus.fp_in    = fp;
    @(posedge clk);
    #1;
    bus.start_in = 1'b0;
    bus.fp_in    = ~fp;
    busy_ok      = (bus.busy_out === 1'b1);
    lat          = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done_out === 1'b1) break;
      if (bus.busy_out !== 1'b1) busy_ok = 1'b0;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".int"}, bus.int_out, exp_int);
    check({tag, ".ovf"}, {31'd0, bus.overflow_out}, {31'd0, exp_ovf});
    check({tag, ".unf"}, {31'd0, bus.underflow_out}, {31'd0, exp_unf});
    check({tag, ".busy_during"}, {31'd0, busy_ok}, 32'd1);
    check({tag, ".busy_at_done"}, {31'd0, bus.busy_out}, 32'd0);
  endtask

  initial begin
    logic seen_done;
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.start_in = 1'b0;
    bus.fp_in    = 32'h0000_0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", {31'd0, bus.busy_out}, 32'd0);
    check("reset.done", {31'd0, bus.done_out}, 32'd0);
    check("reset.int", bus.int_out, 32'h0000_0000);
    check("reset.ovf", {31'd0, bus.overflow_out}, 32'd0);
    check("reset.unf", {31'd0, bus.underflow_out}, 32'd0);
    rst = 1'b0;

    run_op("one",      32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 25);
    run_op("neg5p5",   32'hC0B0_0000, ROUND ? 32'hFFFF_FFFA : 32'hFFFF_FFFB, 1'b0, 1'b0, 23);
    run_op("two23",    32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 2);
    run_op("two24",    32'h4B80_0000, 32'h0100_0000, 1'b0, 1'b0, 3);
    run_op("maxpos",   32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 9);
    run_op("maxneg",   32'hCEFF_FFFF, 32'h8000_0080, 1'b0, 1'b0, 9);
    run_op("two31",    32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2);
    run_op("negtwo31", 32'hCF00_0000, 32'h8000_0000, 1'b1, 1'b0, 2);
    run_op("nan",      32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2);
    run_op("neginf",   32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 2);
    run_op("half",     32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, ROUND ? 26 : 2);
    run_op("threeq",   32'h3F40_0000, ROUND ? 32'h0000_0001 : 32'h0000_0000,
           1'b0, ROUND ? 1'b0 : 1'b1, ROUND ? 26 : 2);
    run_op("zero",     32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 2);
    run_op("negzero",  32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 2);
    run_op("denorm",   32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 2);
    run_op("tiny",     32'h3E80_0000, 32'h0000_0000, 1'b0, 1'b1, 2);

    // Abort a 1.0 conversion with reset on the 10th cycle; a mid-shift start is ignored
    bus.start_in = 1'b1;
    bus.fp_in    = 32'h3F80_0000;
    @(posedge clk);
    #1;
    bus.start_in = 1'b0;
    seen_done    = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 4) begin
        bus.start_in = 1'b1;
        bus.fp_in    = 32'h4B00_0000;
      end else begin
        bus.start_in = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done_out === 1'b1) seen_done = 1'b1;
    end
    bus.start_in = 1'b0;
    check("abort.no_early_done", {31'd0, seen_done}, 32'd0);
    check("abort.busy_before_rst", {31'd0, bus.busy_out}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort.busy", {31'd0, bus.busy_out}, 32'd0);
    check("abort.done", {31'd0, bus.done_out}, 32'd0);
    check("abort.int", bus.int_out, 32'h0000_0000);
    check("abort.flags", {30'd0, bus.overflow_out, bus.underflow_out}, 32'd0);
    run_op("after_rst_two", 32'h4000_0000, 32'h0000_0002, 1'b0, 1'b0, 24);

    // Result must stay held once done has dropped
    repeat (3) @(posedge clk);
    #1;
    check("hold.done", {31'd0, bus.done_out}, 32'd0);
    check("hold.int", bus.int_out, 32'h0000_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
